// File: rtl/wave_writer_pkg.sv
// Shared audio package for the waveform loader.
// Holds the capture FSM state encoding and the number of stream bytes that
// make up one sample. Imported by wave_writer and byte_pair_packer.
package wave_writer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } ww_state_e;

  localparam int BYTES_PER_SAMPLE = 2;

endpackage

// File: rtl/wave_writer_packer.sv
// byte_pair_packer: assembles two little-endian stream bytes into one sample.
// Ports:
//   i_clk, i_rst  - system clock, synchronous active-high reset
//   i_byte        - incoming stream byte
//   i_valid       - i_byte is valid
//   i_ready       - consumer (capture FSM) can take a byte this cycle
//   i_hi_sel      - 1: accepted byte is the high half, 0: the low half
//   o_accept      - handshake completed this cycle
//   o_sample      - {high byte, low byte} as last accepted
module byte_pair_packer
  import wave_writer_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_byte,
  input  logic                          i_valid,
  input  logic                          i_ready,
  input  logic                          i_hi_sel,
  output logic                          o_accept,
  output logic [8*BYTES_PER_SAMPLE-1:0] o_sample
);

  logic [7:0] r_low;
  logic [7:0] r_high;

  assign o_accept = i_valid & i_ready;
  assign o_sample = {r_high, r_low};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_low  <= '0;
      r_high <= '0;
    end else if (o_accept) begin
      if (i_hi_sel) r_high <= i_byte;
      else          r_low  <= i_byte;
    end
  end

endmodule

// File: rtl/wave_writer.sv
// wave_writer: captures a byte stream into main memory as 16-bit samples.
// A start pulse latches min(length_in, BRAM_DEPTH); each sample is taken as
// low byte then high byte and written at consecutive addresses from 0.
// Optional feature: define WAVE_WRITER_CHECKSUM_EN to add checksum_out, the
// modulo-2^16 sum of the samples written by the current capture.
// Ports:
//   clk_in, rst_in          - system clock, synchronous active-high reset
//   start_in, length_in     - begin capture of length_in samples
//   byte_in, byte_valid_in  - incoming stream, byte_ready_out is the ready
//   mem_addr_out/data/we    - main-memory write port
//   busy_out, done_out      - capture in progress / one-cycle completion pulse
//   count_out               - samples written so far
//   checksum_out            - (WAVE_WRITER_CHECKSUM_EN only) running sample sum
module wave_writer
  import wave_writer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BRAM_DEPTH   = 4096,
  parameter int WW_WIDTH     = 12
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [WW_WIDTH-1:0]     length_in,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid_in,
  output logic                    byte_ready_out,
  output logic [WW_WIDTH-1:0]     mem_addr_out,
  output logic [SAMPLE_WIDTH-1:0] mem_data_out,
  output logic                    mem_we_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [WW_WIDTH-1:0]     count_out
`ifdef WAVE_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]             checksum_out
`endif
);

  // One extra bit so a depth of exactly 2^WW_WIDTH is representable.
  localparam logic [WW_WIDTH:0] DEPTH_EXT = (WW_WIDTH + 1)'(BRAM_DEPTH);

  ww_state_e                r_state;
  ww_state_e                w_next;
  logic [WW_WIDTH:0]        r_len;
  logic [WW_WIDTH-1:0]      r_idx;
  logic [WW_WIDTH-1:0]      r_count;
  logic [WW_WIDTH:0]        w_len_ext;
  logic [WW_WIDTH:0]        w_len_clamped;
  logic                     w_len_zero;
  logic                     w_last;
  logic                     w_ready;
  logic                     w_accept;
  logic                     w_start;
  logic [SAMPLE_WIDTH-1:0]  w_sample;

  assign w_len_ext     = {1'b0, length_in};
  assign w_len_clamped = (w_len_ext > DEPTH_EXT) ? DEPTH_EXT : w_len_ext;
  assign w_len_zero    = (r_len == '0);
  assign w_last        = (({1'b0, r_idx} + 1'b1) == r_len);
  assign w_start       = (r_state == IDLE) && start_in;

  // The zero-length decision is made from the latched length in the first
  // cycle after start, so LOW must not offer ready while that decision is
  // pending; this makes an empty capture finish two cycles after start.
  assign w_ready = ((r_state == LOW) && !w_len_zero) || (r_state == HIGH);
  assign byte_ready_out = w_ready;

  byte_pair_packer u_packer (
    .i_clk    (clk_in),
    .i_rst    (rst_in),
    .i_byte   (byte_in),
    .i_valid  (byte_valid_in),
    .i_ready  (w_ready),
    .i_hi_sel (r_state == HIGH),
    .o_accept (w_accept),
    .o_sample (w_sample)
  );

  assign mem_addr_out = r_idx;
  assign mem_data_out = w_sample;
  assign count_out    = r_count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_len   <= w_len_clamped;
        r_idx   <= '0;
        r_count <= '0;
      end else if (r_state == WRITE) begin
        r_count <= r_count + 1'b1;
        // Holding the index on the final sample keeps it within the memory
        // even when the capture fills all BRAM_DEPTH locations.
        if (!w_last) r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    mem_we_out = 1'b0;
    busy_out   = 1'b0;
    done_out   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_in) w_next = LOW;
      end
      LOW: begin
        busy_out = 1'b1;
        if (w_len_zero)    w_next = DONE;
        else if (w_accept) w_next = HIGH;
      end
      HIGH: begin
        busy_out = 1'b1;
        if (w_accept) w_next = WRITE;
      end
      WRITE: begin
        busy_out   = 1'b1;
        mem_we_out = 1'b1;
        w_next     = w_last ? DONE : LOW;
      end
      DONE: begin
        busy_out = 1'b1;
        done_out = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef WAVE_WRITER_CHECKSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge clk_in) begin
    if (rst_in)                 r_csum <= '0;
    else if (w_start)           r_csum <= '0;
    else if (r_state == WRITE)  r_csum <= r_csum + w_sample[15:0];
  end

  assign checksum_out = r_csum;
`endif

endmodule

// File: tb/tb_wave_writer.sv
// Directed bench for wave_writer (BRAM_DEPTH reduced to 8 so the
// over-length capture is reachable with 12-bit lengths).
module tb_wave_writer;
  localparam int SW    = 16;
  localparam int DEPTH = 8;
  localparam int WW    = 12;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic [WW-1:0] length_in = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid_in = 1'b0;
  logic          byte_ready_out;
  logic [WW-1:0] mem_addr_out;
  logic [SW-1:0] mem_data_out;
  logic          mem_we_out;
  logic          busy_out;
  logic          done_out;
  logic [WW-1:0] count_out;
`ifdef WAVE_WRITER_CHECKSUM_EN
  logic [15:0]   checksum_out;
`endif

  wave_writer #(.SAMPLE_WIDTH(SW), .BRAM_DEPTH(DEPTH), .WW_WIDTH(WW)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .length_in      (length_in),
    .byte_in        (byte_in),
    .byte_valid_in  (byte_valid_in),
    .byte_ready_out (byte_ready_out),
    .mem_addr_out   (mem_addr_out),
    .mem_data_out   (mem_data_out),
    .mem_we_out     (mem_we_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .count_out      (count_out)
`ifdef WAVE_WRITER_CHECKSUM_EN
    ,
    .checksum_out   (checksum_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;

  // Event log, filled at the falling edge.
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int ready_seen = 0;
  int ready_in_write = 0;
  int csum_at_done = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (mem_we_out) begin
      wr_addr.push_back(int'(mem_addr_out));
      wr_data.push_back(int'(mem_data_out));
      wr_cyc.push_back(cyc);
      if (byte_ready_out) ready_in_write++;
    end
    if (byte_ready_out) ready_seen++;
    if (done_out) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef WAVE_WRITER_CHECKSUM_EN
      csum_at_done = int'(checksum_out);
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    ready_seen = 0;
    ready_in_write = 0;
    csum_at_done = 0;
  endtask

  task automatic start(input int len);
    length_in = WW'(len);
    start_in  = 1'b1;
    @(negedge clk_in);
    s_cyc = cyc;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 0;
    if (gap > 0) begin
      byte_valid_in = 1'b0;
      repeat (gap) @(posedge clk_in);
      #1;
    end
    byte_valid_in = 1'b1;
    byte_in = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_in);
      if (byte_ready_out) begin
        acc = 1;
        @(posedge clk_in);
        #1;
        break;
      end
    end
    if (!acc) check("byte_accept_timeout", 32'(b), 32'hFFFF_FFFF);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk_in);
      if (done_cnt > 0) begin
        seen = 1;
        break;
      end
    end
    #1;
    if (!seen) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int gaps[6];
    logic [7:0] bytes3[6];
    bit seq_ok;

    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_ready", 32'(byte_ready_out), 32'd0);
    check("rst_we",    32'(mem_we_out),     32'd0);
    check("rst_busy",  32'(busy_out),       32'd0);
    check("rst_done",  32'(done_out),       32'd0);
    check("rst_addr",  32'(mem_addr_out),   32'd0);
    check("rst_data",  32'(mem_data_out),   32'd0);
    check("rst_count", 32'(count_out),      32'd0);
    @(posedge clk_in);
    #1;

    // Two samples, valid held high: peak rate.
    clear_log();
    start(2);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    byte_valid_in = 1'b0;
    wait_done("t1_done_timeout");
    repeat (3) @(posedge clk_in);
    #1;
    check("t1_nwr",    32'(wr_addr.size()), 32'd2);
    check("t1_addr0",  32'(wr_addr[0]), 32'd0);
    check("t1_data0",  32'(wr_data[0]), 32'h1234);
    check("t1_addr1",  32'(wr_addr[1]), 32'd1);
    check("t1_data1",  32'(wr_data[1]), 32'h5678);
    check("t1_lat",    32'(wr_cyc[0] - s_cyc), 32'd3);
    check("t1_rate",   32'(wr_cyc[1] - wr_cyc[0]), 32'd3);
    check("t1_donelat",32'(done_cyc - wr_cyc[1]), 32'd1);
    check("t1_ndone",  32'(done_cnt), 32'd1);
    check("t1_count",  32'(count_out), 32'd2);
    check("t1_idle_busy", 32'(busy_out), 32'd0);

    // Zero length.
    clear_log();
    start(0);
    wait_done("t2_done_timeout");
    repeat (3) @(posedge clk_in);
    #1;
    check("t2_nwr",     32'(wr_addr.size()), 32'd0);
    check("t2_donelat", 32'(done_cyc - s_cyc), 32'd2);
    check("t2_ready",   32'(ready_seen), 32'd0);
    check("t2_ndone",   32'(done_cnt), 32'd1);

    // Three samples with gapped valid.
    clear_log();
    bytes3 = '{8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'hF0, 8'h0F};
    for (int i = 0; i < 6; i++) gaps[i] = int'($urandom_range(0, 3));
    start(3);
    for (int i = 0; i < 6; i++) send_byte(bytes3[i], gaps[i]);
    byte_valid_in = 1'b0;
    wait_done("t3_done_timeout");
    repeat (2) @(posedge clk_in);
    #1;
    check("t3_nwr",   32'(wr_addr.size()), 32'd3);
    check("t3_data0", 32'(wr_data[0]), 32'hA1B2);
    check("t3_data1", 32'(wr_data[1]), 32'hC3D4);
    check("t3_data2", 32'(wr_data[2]), 32'h0FF0);
    check("t3_addr2", 32'(wr_addr[2]), 32'd2);
    check("t3_rdy_wr",32'(ready_in_write), 32'd0);
    check("t3_count", 32'(count_out), 32'd3);

    // Length beyond memory depth is clamped.
    clear_log();
    start(DEPTH + 5);
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(i), 0);
      send_byte(8'(8'h80 | i), 0);
    end
    byte_valid_in = 1'b0;
    wait_done("t4_done_timeout");
    repeat (5) @(posedge clk_in);
    #1;
    seq_ok = 1;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] != i || wr_data[i] != ((32'h80 | i) << 8 | i)) seq_ok = 0;
    check("t4_nwr",   32'(wr_addr.size()), 32'(DEPTH));
    check("t4_last",  32'(wr_addr[DEPTH-1]), 32'(DEPTH - 1));
    check("t4_seq",   32'(seq_ok), 32'd1);
    check("t4_count", 32'(count_out), 32'(DEPTH));
    check("t4_ndone", 32'(done_cnt), 32'd1);

    // Mid-capture start is ignored; checksum when built in.
    clear_log();
    start(2);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    length_in = WW'(5);
    start_in  = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    byte_valid_in = 1'b0;
    wait_done("t5_done_timeout");
    repeat (3) @(posedge clk_in);
    #1;
    check("t5_nwr",   32'(wr_addr.size()), 32'd2);
    check("t5_data1", 32'(wr_data[1]), 32'h0002);
    check("t5_count", 32'(count_out), 32'd2);
`ifdef WAVE_WRITER_CHECKSUM_EN
    check("t5_csum",  32'(csum_at_done), 32'h0001);
`endif

    // Reset one cycle after the first byte of sample 1.
    clear_log();
    start(3);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    byte_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    repeat (10) @(posedge clk_in);
    @(negedge clk_in);
    check("t6_nwr",   32'(wr_addr.size()), 32'd1);
    check("t6_data0", 32'(wr_data[0]), 32'h2211);
    check("t6_ndone", 32'(done_cnt), 32'd0);
    check("t6_busy",  32'(busy_out), 32'd0);
    check("t6_ready", 32'(byte_ready_out), 32'd0);
    check("t6_addr",  32'(mem_addr_out), 32'd0);
    check("t6_data",  32'(mem_data_out), 32'd0);
    check("t6_count", 32'(count_out), 32'd0);
    check("t6_we",    32'(mem_we_out), 32'd0);
`ifdef WAVE_WRITER_CHECKSUM_EN
    check("t6_csum",  32'(checksum_out), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
